st_aligner: RTL and testbench



---
 rtl/st_aligner_pkg.sv | 24 ++
 rtl/st_aligner_lane_shifter.sv | 43 ++++
 rtl/st_aligner.sv | 114 +++++++++++
 tb/tb_st_aligner.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/st_aligner_pkg.sv
// Shared definitions for the data-memory load/store path: func3 codes and
// the store aligner state encoding.
package st_aligner_pkg;

    // Load widths (used by the load data path)
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store widths
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT0 = 2'd1,
        ST_BEAT1 = 2'd2,
        ST_FIN   = 2'd3
    } st_state_t;

endpackage

// File: rtl/st_aligner_lane_shifter.sv
// Combinational store lane math: places right-justified store data into its
// byte lanes across two consecutive words and derives the byte strobes.
module st_lane_shifter
    import st_aligner_pkg::*;
(
    input  logic [2:0]  func3,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    output logic [63:0] sh64,
    output logic [7:0]  st8,
    output logic        split,
    output logic        illegal
);

    logic [31:0] masked;
    logic [7:0]  nmask;

    // Width decode, shift into lanes, detect word-boundary crossing
    always_comb begin
        masked  = '0;
        nmask   = '0;
        illegal = 1'b0;
        case (func3)
            F3_SB: begin
                masked = {24'h0, wdata[7:0]};
                nmask  = 8'b0000_0001;
            end
            F3_SH: begin
                masked = {16'h0, wdata[15:0]};
                nmask  = 8'b0000_0011;
            end
            F3_SW: begin
                masked = wdata;
                nmask  = 8'b0000_1111;
            end
            default: illegal = 1'b1;
        endcase
        sh64  = {32'h0, masked} << {off, 3'b000};
        st8   = nmask << off;
        split = (st8[7:4] != 4'b0000);
    end

endmodule

// File: rtl/st_aligner.sv
// Store aligner: accepts one store request, issues one or two word-aligned
// write beats with byte strobes, then pulses done (with err for bad func3).
module st_aligner
    import st_aligner_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  func3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    output logic        done,
    output logic        err
);

    st_state_t   state;
    logic [63:0] sh64;
    logic [7:0]  st8;
    logic        split;
    logic        illegal;

    // Upper-word beat, held from accept until beat0 completes
    logic [31:0] hi_data;
    logic [3:0]  hi_strb;
    logic        split_q;

    st_lane_shifter u_shift (
        .func3   (func3),
        .off     (addr[1:0]),
        .wdata   (wdata),
        .sh64    (sh64),
        .st8     (st8),
        .split   (split),
        .illegal (illegal)
    );

    assign req_ready = (state == ST_IDLE);

    // Control FSM with registered beat and completion outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            mem_valid <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            hi_data   <= '0;
            hi_strb   <= '0;
            split_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        if (illegal) begin
                            state <= ST_FIN;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else begin
                            state     <= ST_BEAT0;
                            mem_valid <= 1'b1;
                            mem_addr  <= {addr[31:2], 2'b00};
                            mem_wdata <= sh64[31:0];
                            mem_wstrb <= st8[3:0];
                            hi_data   <= sh64[63:32];
                            hi_strb   <= st8[7:4];
                            split_q   <= split;
                        end
                    end
                end
                ST_BEAT0: begin
                    if (mem_ready) begin
                        if (split_q) begin
                            state     <= ST_BEAT1;
                            mem_addr  <= mem_addr + 32'd4;
                            mem_wdata <= hi_data;
                            mem_wstrb <= hi_strb;
                        end else begin
                            state     <= ST_FIN;
                            mem_valid <= 1'b0;
                            mem_addr  <= '0;
                            mem_wdata <= '0;
                            mem_wstrb <= '0;
                            done      <= 1'b1;
                        end
                    end
                end
                ST_BEAT1: begin
                    if (mem_ready) begin
                        state     <= ST_FIN;
                        mem_valid <= 1'b0;
                        mem_addr  <= '0;
                        mem_wdata <= '0;
                        mem_wstrb <= '0;
                        done      <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                    err   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_st_aligner.sv
// Directed bench for st_aligner: hand-computed beats, strobes and timing.
module tb_st_aligner;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  func3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        done;
    logic        err;

    int unsigned errors = 0;
    int unsigned total  = 0;

    st_aligner dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .func3     (func3),
        .addr      (addr),
        .wdata     (wdata),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_beat(input string tag, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] s);
        chk({tag, ".valid"}, {31'b0, mem_valid}, 32'd1);
        chk({tag, ".addr"},  mem_addr, a);
        chk({tag, ".wdata"}, mem_wdata, d);
        chk({tag, ".wstrb"}, {28'b0, mem_wstrb}, {28'b0, s});
        chk({tag, ".done"},  {31'b0, done}, 32'd0);
    endtask

    task automatic chk_idle_mem(input string tag);
        chk({tag, ".valid"}, {31'b0, mem_valid}, 32'd0);
        chk({tag, ".addr"},  mem_addr, 32'd0);
        chk({tag, ".wdata"}, mem_wdata, 32'd0);
        chk({tag, ".wstrb"}, {28'b0, mem_wstrb}, 32'd0);
    endtask

    // Present a request for one cycle; returns at the negedge of cycle N+1
    task automatic accept(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        func3     = f;
        addr      = a;
        wdata     = d;
        req_valid = 1'b1;
        chk("accept.req_ready", {31'b0, req_ready}, 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        func3     = 3'b000;
        addr      = 32'h0;
        wdata     = 32'h0;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        func3     = 3'b000;
        addr      = 32'h0;
        wdata     = 32'h0;
        mem_ready = 1'b1;

        // Reset state
        #12;
        chk_idle_mem("rst");
        chk("rst.req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst.done", {31'b0, done}, 32'd0);
        chk("rst.err",  {31'b0, err},  32'd0);
        @(negedge clk);
        rst = 1'b0;

        // SB, unaligned, single beat
        accept(3'b000, 32'h0000_3001, 32'h0000_00EF);
        chk_beat("sb", 32'h0000_3000, 32'h0000_EF00, 4'b0010);
        chk("sb.req_ready_busy", {31'b0, req_ready}, 32'd0);
        @(negedge clk);
        chk("sb.done", {31'b0, done}, 32'd1);
        chk("sb.err",  {31'b0, err},  32'd0);
        chk_idle_mem("sb.fin");
        chk("sb.fin_ready", {31'b0, req_ready}, 32'd0);
        @(negedge clk);
        chk("sb.done_clr", {31'b0, done}, 32'd0);
        chk("sb.ready_back", {31'b0, req_ready}, 32'd1);

        // SH, upper half of word
        accept(3'b001, 32'h0000_2002, 32'h1234_ABCD);
        chk_beat("sh", 32'h0000_2000, 32'hABCD_0000, 4'b1100);
        @(negedge clk);
        chk("sh.done", {31'b0, done}, 32'd1);
        chk("sh.err",  {31'b0, err},  32'd0);
        @(negedge clk);

        // SW crossing a word, beat0 stalled three cycles
        mem_ready = 1'b0;
        accept(3'b010, 32'h0000_1003, 32'hAABB_CCDD);
        chk_beat("sw.b0.s1", 32'h0000_1000, 32'hDD00_0000, 4'b1000);
        @(negedge clk);
        chk_beat("sw.b0.s2", 32'h0000_1000, 32'hDD00_0000, 4'b1000);
        @(negedge clk);
        chk_beat("sw.b0.s3", 32'h0000_1000, 32'hDD00_0000, 4'b1000);
        mem_ready = 1'b1;
        @(negedge clk);
        chk_beat("sw.b1", 32'h0000_1004, 32'h00AA_BBCC, 4'b0111);
        @(negedge clk);
        chk("sw.done", {31'b0, done}, 32'd1);
        chk_idle_mem("sw.fin");
        @(negedge clk);

        // SH at top of address space wraps beat1 to 0
        accept(3'b001, 32'hFFFF_FFFF, 32'h0000_5678);
        chk_beat("wrap.b0", 32'hFFFF_FFFC, 32'h7800_0000, 4'b1000);
        @(negedge clk);
        chk_beat("wrap.b1", 32'h0000_0000, 32'h0000_0056, 4'b0001);
        @(negedge clk);
        chk("wrap.done", {31'b0, done}, 32'd1);
        @(negedge clk);

        // Illegal func3: no beat, done+err next cycle
        accept(3'b011, 32'h0000_4000, 32'h0BAD_0BAD);
        chk("ill.done", {31'b0, done}, 32'd1);
        chk("ill.err",  {31'b0, err},  32'd1);
        chk_idle_mem("ill");
        chk("ill.req_ready", {31'b0, req_ready}, 32'd0);
        @(negedge clk);
        chk("ill.done_clr", {31'b0, done}, 32'd0);
        chk("ill.err_clr",  {31'b0, err},  32'd0);
        chk("ill.ready_back", {31'b0, req_ready}, 32'd1);

        // Reset during BEAT1 of a split SW
        accept(3'b010, 32'h0000_0102, 32'h1122_3344);
        chk_beat("rs.b0", 32'h0000_0100, 32'h3344_0000, 4'b1100);
        @(negedge clk);
        chk_beat("rs.b1", 32'h0000_0104, 32'h0000_1122, 4'b0011);
        rst = 1'b1;
        #1;
        chk_idle_mem("rs.async");
        chk("rs.req_ready", {31'b0, req_ready}, 32'd1);
        chk("rs.done", {31'b0, done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rs.no_done", {31'b0, done}, 32'd0);
        chk_idle_mem("rs.post");

        // Fresh aligned SW after reset
        accept(3'b010, 32'h0000_0010, 32'hCAFE_F00D);
        chk_beat("sw2", 32'h0000_0010, 32'hCAFE_F00D, 4'b1111);
        @(negedge clk);
        chk("sw2.done", {31'b0, done}, 32'd1);
        chk("sw2.err",  {31'b0, err},  32'd0);
        @(negedge clk);
        chk("sw2.ready_back", {31'b0, req_ready}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, total);
        $finish;
    end

endmodule
